// File: rtl/fp_au_pkg.sv
// Shared FP32 arithmetic-unit definitions: field layout, constants, divider FSM states.
package fp_au_pkg;
  localparam int FP_W   = 32;
  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int MANT_W = 24;
  localparam int SIGN_POS = 31;
  localparam int EXP_LSB  = 23;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;
  localparam logic [FP_W-1:0] QNAN    = 32'h7FC00000;
  localparam logic [FP_W-1:0] POS_INF = 32'h7F800000;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_DIVIDE, S_NORM, S_DONE} state_t;
  typedef enum logic [2:0] {SP_NONE, SP_NAN, SP_INF, SP_ZERO, SP_DZ} spec_t;

  // 10-bit signed exponent adder shared by the AU datapaths
  function automatic logic signed [9:0] add10(input logic signed [9:0] a,
                                              input logic signed [9:0] b);
    return a + b;
  endfunction
endpackage

// File: rtl/divider_seq_div_step.sv
// One restoring-division step: compare/subtract divisor, emit one quotient bit, shift remainder.
module div_step #(
  parameter int MANT_W = 24
) (
  input  logic [MANT_W:0]   r_i,
  input  logic [MANT_W-1:0] d_i,
  output logic              q_o,
  output logic [MANT_W:0]   r_o
);
  logic [MANT_W-1:0] diff;

  // after a successful subtract the remainder is below the divisor, so MANT_W bits suffice
  assign diff = MANT_W'(r_i - {1'b0, d_i});
  assign q_o  = (r_i >= {1'b0, d_i});
  assign r_o  = q_o ? {diff, 1'b0} : {r_i[MANT_W-1:0], 1'b0};
endmodule

// File: rtl/divider_seq.sv
// Iterative FP32 divider with start/busy/done handshake and fixed latency.
// Define ROUND_NEAREST_EN for round-to-nearest-even; default build truncates.
module divider_seq
  import fp_au_pkg::*;
#(
  parameter int QBITS_PER_CYC = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        overflag,
  output logic        underflag,
  output logic        divzero
);
  localparam int N  = 26 / QBITS_PER_CYC;
  localparam int CW = $clog2(N);

  state_t             state_q;
  spec_t              spec_q, spec_d;
  logic [31:0]        a_q, b_q;
  logic               sign_q;
  logic signed [9:0]  exp_q;
  logic [MANT_W-1:0]  mb_q;
  logic [MANT_W:0]    rem_q;
  logic [25:0]        quo_q;
  logic [CW-1:0]      cnt_q;
  logic               busy_q, done_q, ovf_q, unf_q, dz_q;
  logic [31:0]        result_q;

  // operand classification (exp==0 flushes denormals to zero)
  logic [7:0] ea, eb;
  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  assign ea     = a_q[30:EXP_LSB];
  assign eb     = b_q[30:EXP_LSB];
  assign a_zero = (ea == 8'h00);
  assign b_zero = (eb == 8'h00);
  assign a_inf  = (ea == 8'hFF) && (a_q[FRAC_W-1:0] == '0);
  assign b_inf  = (eb == 8'hFF) && (b_q[FRAC_W-1:0] == '0);
  assign a_nan  = (ea == 8'hFF) && (a_q[FRAC_W-1:0] != '0);
  assign b_nan  = (eb == 8'hFF) && (b_q[FRAC_W-1:0] != '0);

  always_comb begin
    spec_d = SP_NONE;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) spec_d = SP_NAN;
    else if (a_inf)  spec_d = SP_INF;
    else if (b_inf)  spec_d = SP_ZERO;
    else if (b_zero) spec_d = SP_DZ;
    else if (a_zero) spec_d = SP_ZERO;
  end

  // restoring step chain, QBITS_PER_CYC bits per cycle
  logic [QBITS_PER_CYC:0][MANT_W:0] r_chain;
  logic [QBITS_PER_CYC-1:0]         qbits;
  assign r_chain[0] = rem_q;
  for (genvar i = 0; i < QBITS_PER_CYC; i++) begin : g_step
    div_step #(.MANT_W(MANT_W)) u_step (
      .r_i (r_chain[i]),
      .d_i (mb_q),
      .q_o (qbits[QBITS_PER_CYC-1-i]),
      .r_o (r_chain[i+1])
    );
  end

  // normalise, round, range check
  logic [FRAC_W-1:0] frac_n;
  logic signed [9:0] exp_n, exp_r;
  logic              inc;
  logic [24:0]       sum;
  logic              ovf_n, unf_n;

  always_comb begin
    if (quo_q[25]) begin
      frac_n = quo_q[24:2];
      exp_n  = exp_q;
    end else begin
      frac_n = quo_q[23:1];
      exp_n  = add10(exp_q, -10'sd1);
    end
`ifdef ROUND_NEAREST_EN
    begin : g_rne
      logic guard, stick;
      guard = quo_q[25] ? quo_q[1] : quo_q[0];
      stick = (quo_q[25] & quo_q[0]) | (|rem_q);
      inc   = guard & (stick | frac_n[0]);
    end
`else
    inc = 1'b0;
`endif
    sum   = {2'b01, frac_n} + 25'(inc);
    exp_r = sum[24] ? add10(exp_n, 10'sd1) : exp_n;
    ovf_n = (exp_r >= 10'sd255);
    unf_n = (exp_r <= 10'sd0);
  end

`ifndef ROUND_NEAREST_EN
  logic unused_lsb;
  assign unused_lsb = quo_q[0];
`endif

  logic [31:0] res_d;
  logic        ovf_d, unf_d, dz_d;
  always_comb begin
    res_d = {sign_q, exp_r[7:0], sum[FRAC_W-1:0]};
    ovf_d = 1'b0;
    unf_d = 1'b0;
    dz_d  = 1'b0;
    case (spec_q)
      SP_NAN:  res_d = QNAN;
      SP_INF:  res_d = {sign_q, POS_INF[30:0]};
      SP_ZERO: res_d = {sign_q, 31'h0};
      SP_DZ: begin
        res_d = {sign_q, POS_INF[30:0]};
        dz_d  = 1'b1;
      end
      default: begin
        if (ovf_n) begin
          res_d = {sign_q, POS_INF[30:0]};
          ovf_d = 1'b1;
        end else if (unf_n) begin
          res_d = {sign_q, 31'h0};
          unf_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      spec_q   <= SP_NONE;
      a_q      <= '0;
      b_q      <= '0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      mb_q     <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= A;
            b_q     <= B;
            busy_q  <= 1'b1;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            dz_q    <= 1'b0;
            state_q <= S_SETUP;
          end
        end
        S_SETUP: begin
          sign_q  <= a_q[SIGN_POS] ^ b_q[SIGN_POS];
          exp_q   <= add10(add10({2'b0, ea}, -{2'b0, eb}), 10'(BIAS));
          rem_q   <= {2'b01, a_q[FRAC_W-1:0]};
          mb_q    <= {1'b1, b_q[FRAC_W-1:0]};
          quo_q   <= '0;
          cnt_q   <= '0;
          spec_q  <= spec_d;
          state_q <= S_DIVIDE;
        end
        S_DIVIDE: begin
          rem_q <= r_chain[QBITS_PER_CYC];
          quo_q <= {quo_q[25-QBITS_PER_CYC:0], qbits};
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(N-1)) state_q <= S_NORM;
        end
        S_NORM: begin
          result_q <= res_d;
          ovf_q    <= ovf_d;
          unf_q    <= unf_d;
          dz_q     <= dz_d;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= S_DONE;
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign overflag  = ovf_q;
  assign underflag = unf_q;
  assign divzero   = dz_q;
endmodule
